aes_round_controller: RTL and testbench
=======================================

Name: aes_round_controller

Overview:
- Parametrised multicycle round sequencer for the AES datapath. It replaces the fixed 10-round, free-running controller.
- Supports AES-128/192/256, encrypt and decrypt, and 1 or 2 rounds per cycle.
- Uses valid/ready handshakes on input and output.
- Drives the shared round datapath and key-schedule index: load strobe, round enable, final-round flag and key index.

Parameters:
- KEY_BITS, 128, key size: 128/192/256. Gives NR = 10/12/14.
- UNROLL, 1, rounds applied per cycle: 1 or 2. The datapath instantiates UNROLL round stages.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  new block and key present on datapath inputs
- in_ready  out  1  controller accepts a block this cycle
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- out_valid  out  1  datapath output holds the result for the last accepted block
- out_ready  in  1  consumer takes the result
- load_en  out  1  datapath captures input XOR round key[round_idx]
- round_en  out  1  datapath applies UNROLL round(s) this cycle
- final_round  out  1  this cycle contains round NR; MixColumns is skipped on the last stage
- round_idx  out  4  key index used by the first stage this cycle
- mode_q  out  1  latched mode of the block in flight
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Next state is IDLE.
  - in_ready = 1; all other outputs = 0, including round_idx = 0.
  - Reset mid-operation abandons the block; out_valid never asserts for it.
- States:
  - IDLE: in_ready = 1.
    - in_valid → accept. In the same cycle: load_en = 1; round_idx = 0 (enc) or NR (dec); mode_q captures in_mode from the next cycle.
    - Next state is RUN.
  - RUN: in_ready = 0; round_en = 1. Lasts NR/UNROLL cycles.
    - Encrypt: round_idx = 1, 1+UNROLL, … up to NR−UNROLL+1.
    - Decrypt: round_idx = NR−1, NR−1−UNROLL, … down to UNROLL−1. For UNROLL = 2, stage 2 uses round_idx−1.
    - final_round = 1 on the last RUN cycle only. Next state is DONE.
  - DONE: out_valid = 1, held stable until out_ready.
    - in_ready = out_ready, so a result can leave and a new block enter in the same cycle.
    - out_ready && in_valid → accept: load_en = 1, next state RUN.
    - out_ready && !in_valid → next state IDLE.
    - !out_ready → stay in DONE.
- Latency and throughput:
  - Accept to first out_valid = NR/UNROLL + 1 cycles.
  - Back-to-back throughput is one block per NR/UNROLL + 1 cycles.
- Ignored inputs: in_valid while in_ready = 0; out_ready while out_valid = 0.
- in_mode is irrelevant outside the accept cycle.
- round_idx holds its last value in DONE and is 0 in IDLE.
- Illegal KEY_BITS or UNROLL values raise an elaboration-time $error.

Optional Feature:
- AES_CTRL_STATS_EN defined:
  - Adds output blk_count [31:0].
  - Increments on each out_valid && out_ready and wraps at 2^32.
  - Cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- aes_ctrl_pkg:
  - state enum (IDLE, RUN, DONE), mode enum (ENC, DEC)
  - function nr_from_key_bits
  - constant IDX_W = 4
- Sub-module aes_round_counter:
  - loadable up/down counter with step UNROLL
  - outputs count and a terminal flag used for final_round

Test Plan:
- Reset: hold rst 2 cycles, release → in_ready = 1, out_valid = 0, round_idx = 0, busy = 0.
- KEY_BITS = 128, UNROLL = 1, encrypt accept at cycle 0:
  - load_en at 0 with round_idx = 0.
  - round_idx 1..10 on cycles 1..10; final_round only at 10.
  - out_valid at 11.
- KEY_BITS = 256, decrypt:
  - Load with round_idx = 14.
  - round_idx 13..0 on cycles 1..14; final_round at idx 0.
  - out_valid at 15; mode_q = 1 throughout.
- Backpressure: out_ready = 0 for 5 cycles in DONE → out_valid held, in_ready = 0. Then out_ready = in_valid = 1 in the same cycle → load_en = 1 that cycle and round_idx = 1 next cycle.
- Reset mid-run at round_idx = 5 → IDLE next cycle; out_valid stays 0; a new accept then runs a full 10 rounds.
- KEY_BITS = 192, UNROLL = 2, encrypt:
  - round_idx 1, 3, 5, 7, 9, 11 on cycles 1..6; final_round at 6.
  - out_valid at 7.
  - With AES_CTRL_STATS_EN, blk_count = 1 after the handshake.

Source files
------------

// File: rtl/aes_round_controller_pkg.sv
// Shared types and helpers for the AES round sequencer: FSM states,
// block direction and the key-size to round-count mapping.
package aes_ctrl_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  // AES round count: 10/12/14 rounds for 128/192/256-bit keys.
  function automatic int nr_from_key_bits(input int key_bits);
    case (key_bits)
      192:     return 12;
      256:     return 14;
      default: return 10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_controller_if.sv
// Valid/ready handshake bundle between the AES controller (slave) and the
// block producer / result consumer (master).
interface aes_round_controller_if;

  logic in_valid;
  logic in_ready;
  logic in_mode;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid, in_mode, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, in_mode, out_ready,
    output in_ready, out_valid
  );

endinterface

// File: rtl/aes_round_controller_round_counter.sv
// Key-index counter for the round datapath. Loaded with the first RUN index
// on accept, then stepped by UNROLL in the block's direction. term_o flags
// the index of the cycle that contains round NR.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NR     = 10,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             down_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] count_o,
  output logic             term_o
);

  localparam logic [IDX_W-1:0] STEP     = IDX_W'(UNROLL);
  localparam logic [IDX_W-1:0] UP_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0] DN_FIRST = IDX_W'(NR - 1);
  localparam logic [IDX_W-1:0] UP_LAST  = IDX_W'(NR - UNROLL + 1);
  localparam logic [IDX_W-1:0] DN_LAST  = IDX_W'(UNROLL - 1);

  logic [IDX_W-1:0] count_q, count_d;
  logic             down_q, down_d;

  // Load takes priority; otherwise step toward the terminal index.
  always_comb begin
    count_d = count_q;
    down_d  = down_q;
    if (load_i) begin
      down_d  = down_i;
      count_d = down_i ? DN_FIRST : UP_FIRST;
    end else if (en_i) begin
      count_d = down_q ? (count_q - STEP) : (count_q + STEP);
    end
  end

  // Counter and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      down_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      down_q  <= down_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = down_q ? (count_q == DN_LAST) : (count_q == UP_LAST);

endmodule

// File: rtl/aes_round_controller.sv
// Multicycle AES round sequencer: accepts a block, runs NR/UNROLL round
// cycles on the shared datapath, then holds the result until taken.
// Optional build macro: AES_CTRL_STATS_EN adds the blk_count output, a
// wrapping count of completed output handshakes.
module aes_round_controller
  import aes_ctrl_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int UNROLL   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_round_controller_if.slave  hs,
  output logic                   load_en,
  output logic                   round_en,
  output logic                   final_round,
  output logic [IDX_W-1:0]       round_idx,
  output logic                   mode_q,
  output logic                   busy
`ifdef AES_CTRL_STATS_EN
  , output logic [31:0]          blk_count
`endif
);

  localparam int NR = nr_from_key_bits(KEY_BITS);
  localparam logic [IDX_W-1:0] DEC_LOAD_IDX = IDX_W'(NR);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_round_controller: KEY_BITS must be 128, 192 or 256");
  end
  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("aes_round_controller: UNROLL must be 1 or 2");
  end

  state_e           state_q, state_d;
  logic             mode_d;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_c;
  logic [IDX_W-1:0] cnt;
  logic             term;
  logic [IDX_W-1:0] load_idx;

  // Encrypt starts from key 0, decrypt from key NR.
  assign load_idx = (hs.in_mode == DEC) ? DEC_LOAD_IDX : '0;

  aes_round_counter #(
    .NR     (NR),
    .UNROLL (UNROLL)
  ) u_round_counter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .down_i  (hs.in_mode == DEC),
    .en_i    (round_en & ~term),
    .count_o (cnt),
    .term_o  (term)
  );

  // Next state and datapath strobes; DONE can hand off straight into RUN.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    round_en    = 1'b0;
    final_round = 1'b0;
    round_idx   = cnt;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        round_idx  = '0;
        if (hs.in_valid) begin
          accept    = 1'b1;
          round_idx = load_idx;
          state_d   = RUN;
        end
      end
      RUN: begin
        round_en    = 1'b1;
        final_round = term;
        if (term) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = hs.out_ready;
        if (hs.out_ready) begin
          if (hs.in_valid) begin
            accept    = 1'b1;
            round_idx = load_idx;
            state_d   = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mode_d = accept ? hs.in_mode : mode_q;

  // State and latched block direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  assign load_en      = accept;
  assign busy         = (state_q != IDLE);
  assign hs.in_ready  = in_ready_c;
  assign hs.out_valid = out_valid_c;

`ifdef AES_CTRL_STATS_EN
  logic [31:0] blk_count_q, blk_count_d;

  assign blk_count_d = (out_valid_c && hs.out_ready) ? (blk_count_q + 32'd1) : blk_count_q;

  // Completed-block counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) blk_count_q <= '0;
    else     blk_count_q <= blk_count_d;
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: three configurations (128/x1, 256/x1,
// 192/x2) checked against a cycle-count reference model, table-driven
// block runs, backpressure and mid-run reset sequences, then random traffic.
module tb_aes_round_controller;

  localparam int NI = 3;

  typedef struct packed {
    logic       ir;
    logic       ov;
    logic       ld;
    logic       re;
    logic       fr;
    logic       mq;
    logic       by;
    logic [3:0] ix;
  } obs_t;

  typedef struct packed {
    logic iv;
    logic im;
    logic ordy;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv   [NI];
  logic       im   [NI];
  logic       ordy [NI];
  logic       ir_w [NI];
  logic       ov_w [NI];
  logic       ld_w [NI];
  logic       re_w [NI];
  logic       fr_w [NI];
  logic       mq_w [NI];
  logic       by_w [NI];
  logic [3:0] ix_w [NI];
`ifdef AES_CTRL_STATS_EN
  logic [31:0] bc_w [NI];
`endif

  int          k_m    [NI];
  logic        mode_m [NI];
  logic [31:0] blk_m  [NI];
  obs_t        exp_a  [NI];

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [$];
  bit   found;
  int   lat;

  always #5 clk = ~clk;

  function automatic int kb_of(int i);
    return (i == 0) ? 128 : (i == 1) ? 256 : 192;
  endfunction

  function automatic int u_of(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // AES: Nr = Nk + 6, with Nk the key length in 32-bit words.
  function automatic int nr_of(int i);
    return 6 + kb_of(i) / 32;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    aes_round_controller_if bus ();
    assign bus.in_valid  = iv[gi];
    assign bus.in_mode   = im[gi];
    assign bus.out_ready = ordy[gi];
    assign ir_w[gi]      = bus.in_ready;
    assign ov_w[gi]      = bus.out_valid;

    aes_round_controller #(.KEY_BITS(kb_of(gi)), .UNROLL(u_of(gi))) dut (
      .clk         (clk),
      .rst         (rst),
      .hs          (bus),
      .load_en     (ld_w[gi]),
      .round_en    (re_w[gi]),
      .final_round (fr_w[gi]),
      .round_idx   (ix_w[gi]),
      .mode_q      (mq_w[gi]),
      .busy        (by_w[gi])
`ifdef AES_CTRL_STATS_EN
      , .blk_count (bc_w[gi])
`endif
    );
  end

  // Reference: k = 0 no block, k = 1..R is the k-th round cycle, k = R+1 result waiting.
  function automatic obs_t model_out(int nr, int u, int k, logic mode, logic v, logic m, logic rdy);
    obs_t e = '0;
    int   r = nr / u;
    e.mq = mode;
    if (k == 0) begin
      e.ir = 1'b1;
      if (v) begin
        e.ld = 1'b1;
        e.ix = m ? 4'(nr) : 4'd0;
      end
    end else if (k <= r) begin
      e.by = 1'b1;
      e.re = 1'b1;
      e.fr = (k == r);
      e.ix = mode ? 4'(nr - 1 - (k - 1) * u) : 4'(1 + (k - 1) * u);
    end else begin
      e.by = 1'b1;
      e.ov = 1'b1;
      e.ir = rdy;
      if (rdy && v) begin
        e.ld = 1'b1;
        e.ix = m ? 4'(nr) : 4'd0;
      end else begin
        e.ix = mode ? 4'(u - 1) : 4'(nr - u + 1);
      end
    end
    return e;
  endfunction

  always_comb begin
    exp_a = '{default: '0};
    for (int i = 0; i < NI; i++)
      exp_a[i] = model_out(nr_of(i), u_of(i), k_m[i], mode_m[i], iv[i], im[i], ordy[i]);
  end

  always @(posedge clk) begin
    for (int j = 0; j < NI; j++) begin
      if (rst) begin
        k_m[j]    <= 0;
        mode_m[j] <= 1'b0;
        blk_m[j]  <= '0;
      end else begin
        if (exp_a[j].ov && ordy[j]) blk_m[j] <= blk_m[j] + 32'd1;
        if (exp_a[j].ld) begin
          k_m[j]    <= 1;
          mode_m[j] <= im[j];
        end else if (k_m[j] >= 1 && k_m[j] <= nr_of(j) / u_of(j)) begin
          k_m[j] <= k_m[j] + 1;
        end else if (exp_a[j].ov && ordy[j]) begin
          k_m[j] <= 0;
        end
      end
    end
  end

  function automatic obs_t observe(int i);
    return {ir_w[i], ov_w[i], ld_w[i], re_w[i], fr_w[i], mq_w[i], by_w[i], ix_w[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_check_all();
    for (int i = 0; i < NI; i++) begin
      obs_t gv = observe(i);
      n_cmp++;
      if (gv !== exp_a[i]) begin
        n_bad++;
        $display("FAIL model[%0d] @%0t: got %h, expected %h", i, $time, gv, exp_a[i]);
      end
`ifdef AES_CTRL_STATS_EN
      chk($sformatf("blk_count[%0d]", i), bc_w[i], blk_m[i]);
`endif
    end
  endtask

  task automatic tick();
    model_check_all();
    @(posedge clk);
    #1;
  endtask

  // One block from accept to hand-off; in_valid/out_ready are held high
  // during RUN and in_mode is flipped there, all of which must be ignored.
  task automatic build_tbl(int i, bit dec, logic prev_mode);
    int   nr = nr_of(i);
    int   u  = u_of(i);
    int   r  = nr / u;
    vec_t v;
    tbl.delete();
    v = '0; v.iv = 1'b1; v.im = dec;
    v.e.ld = 1'b1; v.e.ir = 1'b1; v.e.mq = prev_mode; v.e.ix = dec ? 4'(nr) : 4'd0;
    tbl.push_back(v);
    for (int k = 1; k <= r; k++) begin
      v = '0; v.iv = 1'b1; v.im = ~dec; v.ordy = 1'b1;
      v.e.re = 1'b1; v.e.by = 1'b1; v.e.mq = dec; v.e.fr = (k == r);
      v.e.ix = dec ? 4'(nr - 1 - (k - 1) * u) : 4'(1 + (k - 1) * u);
      tbl.push_back(v);
    end
    v = '0; v.ordy = 1'b1;
    v.e.ov = 1'b1; v.e.ir = 1'b1; v.e.by = 1'b1; v.e.mq = dec;
    v.e.ix = dec ? 4'(u - 1) : 4'(nr - u + 1);
    tbl.push_back(v);
  endtask

  task automatic run_tbl(int i, string name);
    foreach (tbl[r]) begin
      iv[i]   = tbl[r].iv;
      im[i]   = tbl[r].im;
      ordy[i] = tbl[r].ordy;
      @(negedge clk);
      n_cmp++;
      if (observe(i) !== tbl[r].e) begin
        n_bad++;
        $display("FAIL %s row %0d: got %h, expected %h", name, r, observe(i), tbl[r].e);
      end
      tick();
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; im[i] = 1'b0; ordy[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset in_ready[%0d]", i),  ir_w[i], 1);
      chk($sformatf("reset out_valid[%0d]", i), ov_w[i], 0);
      chk($sformatf("reset round_idx[%0d]", i), ix_w[i], 0);
      chk($sformatf("reset busy[%0d]", i),      by_w[i], 0);
    end
    tick();

    build_tbl(0, 1'b0, 1'b0);
    run_tbl(0, "aes128 enc");
    build_tbl(1, 1'b1, 1'b0);
    run_tbl(1, "aes256 dec");
    build_tbl(2, 1'b0, 1'b0);
    run_tbl(2, "aes192 x2 enc");
`ifdef AES_CTRL_STATS_EN
    @(negedge clk);
    chk("blk_count after aes192 block", bc_w[2], 32'd1);
    tick();
`endif

    // Backpressure in DONE, then same-cycle hand-off of result and new block.
    iv[0] = 1'b1; im[0] = 1'b0; ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ov_w[0]) found = 1'b1;
      else tick();
    end
    chk("bp out_valid reached", found, 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp out_valid held", ov_w[0], 1);
      chk("bp in_ready low", ir_w[0], 0);
      tick();
    end
    iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp load_en on hand-off", ld_w[0], 1);
    chk("bp in_ready follows out_ready", ir_w[0], 1);
    tick();
    iv[0] = 1'b0;
    @(negedge clk);
    chk("bp round_idx after hand-off", ix_w[0], 1);
    chk("bp round_en after hand-off", re_w[0], 1);
    tick();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ov_w[0]) found = 1'b1;
      else tick();
    end
    chk("bp second result", found, 1);
    tick();

    // Reset while round 5 is in flight.
    iv[0] = 1'b1; im[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (re_w[0] && ix_w[0] == 4'd5) found = 1'b1;
      else tick();
    end
    chk("rst reached round 5", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy cleared", by_w[0], 0);
    chk("rst in_ready", ir_w[0], 1);
    chk("rst round_idx", ix_w[0], 0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      chk("rst abandoned block never valid", ov_w[0], 0);
      tick();
    end
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    lat = 1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ov_w[0]) found = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    chk("rst new block latency", lat, 11);
    tick();

    // Random traffic on all three configurations, with occasional reset.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NI; i++) begin
        iv[i]   = 1'($urandom_range(0, 1));
        im[i]   = 1'($urandom_range(0, 1));
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
